// File: rtl/mem_bus_pkg.sv
// Shared widths, wait-counter width and FSM state type for the memory responder.
package mem_bus_pkg;

  localparam int unsigned AddrW    = 32;
  localparam int unsigned DataW    = 32;
  localparam int unsigned MaskW    = 4;
  localparam int unsigned WaitCntW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StRespond
  } mem_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Valid/ready memory bus between a requester (master) and the responder (slave).
interface mem_responder_if;
  import mem_bus_pkg::*;

  logic             mem_valid;
  logic [AddrW-1:0] mem_addr;
  logic [MaskW-1:0] mem_wmask;
  logic [DataW-1:0] mem_wdata;
  logic [DataW-1:0] mem_rdata;
  logic             mem_ready;
  logic             mem_err;

  modport master (
    output mem_valid, mem_addr, mem_wmask, mem_wdata,
    input  mem_rdata, mem_ready, mem_err
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wmask, mem_wdata,
    output mem_rdata, mem_ready, mem_err
  );

endinterface

// File: rtl/mem_responder_ram.sv
// Single-port synchronous RAM with per-byte write enables and registered read data.
module mem_responder_ram
  import mem_bus_pkg::*;
#(
  parameter int unsigned Depth = 2048,
  parameter int unsigned IdxW  = 11
) (
  input  logic             clk,
  input  logic [MaskW-1:0] we,
  input  logic [IdxW-1:0]  addr,
  input  logic [DataW-1:0] wdata,
  output logic [DataW-1:0] rdata
);

  logic [DataW-1:0] mem [Depth];

  // Read-before-write; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(MaskW); i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: IDLE/WAIT/ACCESS/RESPOND FSM in front of a byte-write RAM.
// Define MEM_RESPONDER_ERR_EN to flag out-of-range accesses instead of wrapping the index.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE_KB = 8,
  parameter int unsigned WAIT_CYCLES    = 0
) (
  input  logic            clk,
  input  logic            resetn,
  mem_responder_if.slave  bus
);

  localparam int unsigned Depth = MEMORY_SIZE_KB * 256;
  localparam int unsigned IdxW  = $clog2(Depth);
  localparam logic [WaitCntW-1:0] WaitLoad =
    (WAIT_CYCLES > 0) ? WaitCntW'(WAIT_CYCLES - 1) : '0;

`ifdef MEM_RESPONDER_ERR_EN
  localparam int unsigned LatchW = AddrW - 2;
`else
  localparam int unsigned LatchW = IdxW;
`endif

  mem_state_e          state_q, state_d;
  logic [WaitCntW-1:0] cnt_q, cnt_d;
  logic [LatchW-1:0]   idx_q;
  logic [MaskW-1:0]    wmask_q;
  logic [DataW-1:0]    wdata_q;
  logic                accept;
  logic                rd_ok;
  logic [MaskW-1:0]    ram_we;
  logic [DataW-1:0]    ram_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.mem_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAccess:  state_d = StRespond;
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= bus.mem_addr[LatchW+1:2];
        wmask_q <= bus.mem_wmask;
        wdata_q <= bus.mem_wdata;
      end
    end
  end

`ifdef MEM_RESPONDER_ERR_EN
  assign rd_ok       = 32'(idx_q) < Depth;
  assign ram_we      = (state_q == StAccess && rd_ok) ? wmask_q : '0;
  assign bus.mem_err = (state_q == StRespond) && !rd_ok;
`else
  assign rd_ok       = 1'b1;
  assign ram_we      = (state_q == StAccess) ? wmask_q : '0;
  assign bus.mem_err = 1'b0;
`endif

  assign bus.mem_ready = (state_q == StRespond);
  // Zero for writes, rejected reads and every non-RESPOND cycle keeps the bus stable.
  assign bus.mem_rdata = (state_q == StRespond && wmask_q == '0 && rd_ok) ? ram_rdata : '0;

  mem_responder_ram #(
    .Depth (Depth),
    .IdxW  (IdxW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (idx_q[IdxW-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule
